// File: rtl/wshb_stream_pkg.sv
// Shared types and constants for the Wishbone video-stream sink.
// The pixel-index width is sized for the default 800x480 frame.
package wshb_stream_pkg;

  localparam int unsigned HDISP_DEF = 800;
  localparam int unsigned VDISP_DEF = 480;
  localparam int unsigned IDX_W     = $clog2(HDISP_DEF * VDISP_DEF);

  localparam logic [3:0] SEL_FULL = 4'hF;

  // Status word returned on reads: {frame_cnt, fill level}
  localparam int unsigned STAT_LEVEL_LSB = 0;
  localparam int unsigned STAT_FRAME_LSB = 16;
  localparam int unsigned STAT_FIELD_W   = 16;

  typedef struct packed {
    logic [31:0]      data;
    logic [IDX_W-1:0] idx;
  } pix_entry_t;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } req_state_t;

  function automatic logic [31:0] pack_status(input logic [STAT_FIELD_W-1:0] frame,
                                              input logic [STAT_FIELD_W-1:0] level);
    logic [31:0] word;
    word = '0;
    word[STAT_FRAME_LSB +: STAT_FIELD_W] = frame;
    word[STAT_LEVEL_LSB +: STAT_FIELD_W] = level;
    return word;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Show-ahead synchronous FIFO: the head entry is presented combinationally
// whenever the FIFO is not empty, and reads as zero when it is empty.
module stream_fifo
  import wshb_stream_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter type         entry_t = pix_entry_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  entry_t                   wr_data,
  input  logic                     pop,
  output entry_t                   rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // NOTE: the storage array carries no reset; validity is tracked by level,
  // and the empty-gated read port keeps stale contents off the output.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/wshb_stream_sink.sv
// Wishbone classic responder for the video stream: validates pixel writes,
// queues them with their index, and answers reads with a status word.
module wshb_stream_sink
  import wshb_stream_pkg::*;
#(
  parameter int unsigned HDISP      = HDISP_DEF,
  parameter int unsigned VDISP      = VDISP_DEF,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             cyc,
  input  logic             stb,
  input  logic             we,
  input  logic [31:0]      adr,
  input  logic [31:0]      dat_ms,
  input  logic [3:0]       sel,
  output logic             ack,
  output logic             err,
  output logic             rty,
  output logic [31:0]      dat_sm,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [31:0]      pix_data,
  output logic [IDX_W-1:0] pix_idx,
  output logic             eof
);

  localparam int unsigned PIX_TOTAL = HDISP * VDISP;
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [29:0]      PIX_LIMIT = 30'(PIX_TOTAL);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PIX_TOTAL - 1);

  req_state_t         state_q, state_d;
  logic               ack_d, err_d, eof_d;
  logic [31:0]        dat_sm_d;
  logic [15:0]        frame_cnt;
  logic               frame_inc;
  logic               push;
  logic               fifo_full, fifo_empty;
  logic [LVL_W-1:0]   fifo_level;
  logic               addr_ok;
  pix_entry_t         wr_entry, head;

  assign wr_entry = '{data: dat_ms, idx: adr[IDX_W+1:2]};
  assign addr_ok  = (sel == SEL_FULL) && (adr[1:0] == 2'b00) && (adr[31:2] < PIX_LIMIT);

  stream_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (pix_entry_t)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pix_valid & pix_ready),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign pix_valid = ~fifo_empty;
  assign pix_data  = head.data;
  assign pix_idx   = head.idx;
  assign rty       = 1'b0;

  // ACK/ERR are only ever high in RESP, so IDLE alone implies ~ack & ~err.
  // A full FIFO keeps us in IDLE, re-evaluating the held request each cycle.
  // NOTE: every combinational output gets a default first so no path leaves
  // a signal unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    eof_d     = 1'b0;
    dat_sm_d  = '0;
    push      = 1'b0;
    frame_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cyc && stb) begin
          if (!we) begin
            ack_d    = 1'b1;
            dat_sm_d = pack_status(frame_cnt, STAT_FIELD_W'(fifo_level));
            state_d  = ST_RESP;
          end else if (!addr_ok) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (!fifo_full) begin
            push    = 1'b1;
            ack_d   = 1'b1;
            state_d = ST_RESP;
            if (wr_entry.idx == LAST_IDX) begin
              eof_d     = 1'b1;
              frame_inc = 1'b1;
            end
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      ack       <= 1'b0;
      err       <= 1'b0;
      eof       <= 1'b0;
      dat_sm    <= '0;
      frame_cnt <= '0;
    end else begin
      state_q <= state_d;
      ack     <= ack_d;
      err     <= err_d;
      eof     <= eof_d;
      dat_sm  <= dat_sm_d;
      if (frame_inc) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: doc/wshb_stream_sink.md
# wshb_stream_sink

Wishbone classic responder terminating the video-stream bus mastered by the hardware support block (the `wshb_if_stream` side, today tied off with constant ack). Accepts 32-bit pixel writes, validates address and byte-select, and buffers accepted pixels in a FIFO. Presents them, with their pixel index, on a valid/ready port toward the framebuffer writer. Runs entirely in the `sys_clk` domain.

## Interface
- `HDISP`, 800, active pixels per line
- `VDISP`, 480, active lines per frame
- `FIFO_DEPTH`, 16, pixel FIFO entries; power of two, ≥ 4

- `sys_clk`  in  1  system clock, 100 MHz
- `sys_rst_n`  in  1  reset, synchronous, active-low
- `cyc`, `stb`, `we`  in  1 each  Wishbone cycle, strobe, write enable
- `adr`  in  32  byte address
- `dat_ms`  in  32  write data
- `sel`  in  4  byte selects
- `ack`, `err`, `rty`  out  1 each  Wishbone termination; `rty` tied 0
- `dat_sm`  out  32  read data
- `pix_valid`  out  1  FIFO head valid
- `pix_ready`  in  1  downstream accepts head
- `pix_data`  out  32  pixel word
- `pix_idx`  out  IDX_W  pixel index, IDX_W = $clog2(HDISP*VDISP)
- `eof`  out  1  one-cycle pulse, last pixel of frame accepted

## Operation
- Request = `cyc & stb & ~ack & ~err`, sampled on a rising edge.
- Write request:
  - `sel != 4'hF`, `adr[1:0] != 0`, or `adr[31:2] >= HDISP*VDISP` -> `err` pulse, no push.
  - Otherwise, if FIFO not full -> push {`dat_ms`, `adr[IDX_W+1:2]`} and pulse `ack`.
  - If FIFO full -> no response (wait state). The request is re-evaluated every cycle until space frees.
- Read request: always `ack`, never `err`. `dat_sm` = {`frame_cnt[15:0]`, zero-extended FIFO fill level}. `dat_sm` is 0 whenever `ack` is low.
- `frame_cnt`: 16 bits, increments when index HDISP*VDISP-1 is pushed; wraps 0xFFFF -> 0. `eof` pulses in the same cycle as that push's `ack`.
- FIFO: show-ahead. Pop when `pix_valid & pix_ready`.
  - Push and pop in the same cycle are both honoured; level is unchanged.
  - Fullness is judged on the registered level before the edge, so a pop does not free space for a push in the same cycle.
- Dropping `cyc` or `stb` before termination abandons the request; nothing is pushed.

## Timing
- Reset values:
  - `ack`, `err`, `rty`, `eof`, `pix_valid` = 0
  - `dat_sm`, `pix_data`, `pix_idx` = 0
  - FIFO empty, `frame_cnt` = 0
- `ack`/`err` are registered and asserted 1 cycle after the request edge (minimum latency 1, unbounded when full).
- `ack` and `err` are single-cycle, mutually exclusive, and never asserted in two consecutive cycles. Maximum write throughput is 1 per 2 cycles.
- Pushed entry is visible on `pix_valid` the cycle after the push edge, coincident with `ack`.
- `pix_data`/`pix_idx` are stable while `pix_valid & ~pix_ready`.
- Reset mid-transfer: the pending request is dropped with no termination, the FIFO is flushed, and `frame_cnt` clears. Reset takes precedence over all other events.

## Structure
- Package `wshb_stream_pkg`:
  - `pix_entry_t` struct {data[31:0], idx[IDX_W-1:0]}
  - localparams: `SEL_FULL = 4'hF`, status field offsets
- Sub-module `stream_fifo`: synchronous, parameterised on depth and `pix_entry_t`. Provides `push`, `pop`, `full`, `empty`, `level` ([$clog2(FIFO_DEPTH):0]). The top contains only the request FSM (IDLE -> RESP -> IDLE; RESP lasts 1 cycle) and `frame_cnt`.

## Test plan
- Reset, then write `adr`=0x0, data 0xA5A5A5A5, `sel`=F -> `ack` 1 cycle later; `pix_valid`=1, `pix_idx`=0, `pix_data`=0xA5A5A5A5.
- `pix_ready`=0, 17 writes -> 16 acks; the 17th stalls. Raise `pix_ready` for 1 cycle -> 17th acked on the next cycle; level stays 16.
- Write with `sel`=4'h3, write to `adr`=0x2, and write to `adr`=4*384000 -> `err` each time; FIFO level unchanged, no `ack`.
- Stream 384000 sequential writes, `pix_ready`=1 -> `eof` pulses exactly once with the last ack; a subsequent read returns `dat_sm[31:16]`=1.
- Fill 5 entries, then read -> `dat_sm`=0x00000005. Assert `sys_rst_n`=0 during a stalled write -> no ack, `pix_valid`=0, and a following read returns 0.
- Simultaneous push and pop at level 8 -> level 8 and the FIFO head advances; ordering is checked against a scoreboard over random `pix_ready` for 10k writes.
